// File: rtl/mcb_port_emu_pkg.sv
// mcb_emu_pkg -- shared definitions for the MCB user-port emulator.
//   Instruction codes for cmd_instr, the engine state enum, FIFO depths
//   and the FIFO occupancy count width.
//   Optional feature macro used by the top: MCB_EMU_LATENCY_EN.
package mcb_emu_pkg;

    localparam logic [2:0] INSTR_WR      = 3'b000;
    localparam logic [2:0] INSTR_RD      = 3'b001;
    localparam logic [2:0] INSTR_WR_AP   = 3'b010;
    localparam logic [2:0] INSTR_RD_AP   = 3'b011;
    localparam logic [2:0] INSTR_REFRESH = 3'b100;

    localparam int CMD_DEPTH  = 4;
    localparam int DATA_DEPTH = 64;
    localparam int COUNT_W    = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_WRITE,
        ST_READ,
        ST_DRAIN
    } emu_state_t;

    // Auto-precharge variants behave exactly like the plain commands.
    function automatic logic is_wr_instr(input logic [2:0] instr);
        return (instr == INSTR_WR) || (instr == INSTR_WR_AP);
    endfunction

    function automatic logic is_rd_instr(input logic [2:0] instr);
        return (instr == INSTR_RD) || (instr == INSTR_RD_AP);
    endfunction

endpackage

// File: rtl/mcb_port_emu_if.sv
// mcb_port_emu_if -- cmd/wr/rd FIFO bundle of one MCB user port.
//   master : initiator side (uart_mcu, vga_driverX, testbench)
//   slave  : responder side (mcb_port_emu)
//   Signals: calib_done; cmd_en/instr/bl/byte_addr, cmd_full/empty;
//            wr_en/mask/data, wr_full/empty/count/underrun;
//            rd_en, rd_data, rd_full/empty/count/overflow.
interface mcb_port_emu_if;
    import mcb_emu_pkg::*;

    logic               calib_done;
    logic               cmd_en;
    logic [2:0]         cmd_instr;
    logic [5:0]         cmd_bl;
    logic [29:0]        cmd_byte_addr;
    logic               cmd_full;
    logic               cmd_empty;
    logic               wr_en;
    logic [3:0]         wr_mask;
    logic [31:0]        wr_data;
    logic               wr_full;
    logic               wr_empty;
    logic [COUNT_W-1:0] wr_count;
    logic               wr_underrun;
    logic               rd_en;
    logic [31:0]        rd_data;
    logic               rd_full;
    logic               rd_empty;
    logic [COUNT_W-1:0] rd_count;
    logic               rd_overflow;

    modport master (
        output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_mask, wr_data, rd_en,
        input  calib_done, cmd_full, cmd_empty, wr_full, wr_empty, wr_count, wr_underrun,
               rd_data, rd_full, rd_empty, rd_count, rd_overflow
    );

    modport slave (
        input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_mask, wr_data, rd_en,
        output calib_done, cmd_full, cmd_empty, wr_full, wr_empty, wr_count, wr_underrun,
               rd_data, rd_full, rd_empty, rd_count, rd_overflow
    );

endinterface

// File: rtl/mcb_port_emu_fifo.sv
// emu_sync_fifo -- single-clock FIFO with registered count/full/empty.
//   clk_50m, sys_rst_i (async, active-low)
//   push/din  : write side, ignored when full
//   pop/dout  : read side, ignored when empty
//   full, empty, count : registered, updated on the edge of the push/pop
//   FWFT=1 : dout shows the head word (0 while empty)
//   FWFT=0 : dout is registered on each pop
//   DEPTH must be a power of two.
module emu_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter bit FWFT  = 1'b1,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_50m,
    input  logic             sys_rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk_50m) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Flags are computed from the old count so they land on the same edge.
    always_ff @(posedge clk_50m or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
                empty <= 1'b0;
                full  <= (count == CNT_W'(DEPTH - 1));
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
                full  <= 1'b0;
                empty <= (count == CNT_W'(1));
            end
        end
    end

    if (FWFT) begin : g_fwft
        assign dout = empty ? '0 : mem[rd_ptr];
    end else begin : g_reg
        logic [WIDTH-1:0] dout_q;
        always_ff @(posedge clk_50m or negedge sys_rst_i) begin
            if (!sys_rst_i) begin
                dout_q <= '0;
            end else if (do_pop) begin
                dout_q <= mem[rd_ptr];
            end
        end
        assign dout = dout_q;
    end

endmodule

// File: rtl/mcb_port_emu.sv
// mcb_port_emu -- block-RAM stand-in for one 32-bit bidirectional
// Spartan-6 MCB user port.
//   clk_50m   : sole clock
//   sys_rst_i : async, active-low reset (RAM contents are kept)
//   port      : mcb_port_emu_if.slave (cmd/wr/rd FIFO handshakes)
//   Parameters: ADDR_W (RAM word-address bits), CALIB_CYCLES,
//               CMD_GAP (used only with MCB_EMU_LATENCY_EN).
//   Macro MCB_EMU_LATENCY_EN : insert CMD_GAP idle cycles before each rd/wr.
module mcb_port_emu
    import mcb_emu_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int CALIB_CYCLES = 1000,
    parameter int CMD_GAP      = 8
) (
    input  logic          clk_50m,
    input  logic          sys_rst_i,
    mcb_port_emu_if.slave port
);

    localparam int CMD_W = 3 + 6 + ADDR_W;

    logic [31:0]        calib_cnt;
    logic               calib_done_q;

    logic [CMD_W-1:0]   cmd_head;
    logic               cmd_full_raw;
    logic               cmd_empty_w;
    logic               cmd_pop;
    logic [2:0]         head_instr;
    logic [5:0]         head_bl;
    logic [ADDR_W-1:0]  head_addr;

    logic [35:0]        wr_head;
    logic               wr_empty_w;
    logic               wr_pop;

    logic [COUNT_W-1:0] rd_count_w;
    logic [7:0]         rd_pending;
    logic               rd_room;

    emu_state_t         state_q, state_d;
    logic [6:0]         remaining_q, remaining_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               ram_we;
    logic               ram_re;

    logic [31:0]        mem [2**ADDR_W];
    logic [31:0]        ram_q;
    logic               ram_q_valid;
    logic [31:0]        ret_data;
    logic               ret_valid;

`ifdef MCB_EMU_LATENCY_EN
    logic [15:0]        gap_q, gap_d;
    logic               op_rd_q, op_rd_d;
`endif

    // calib_done rises on the CALIB_CYCLES-th edge after reset release.
    always_ff @(posedge clk_50m or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            calib_cnt    <= '0;
            calib_done_q <= 1'b0;
        end else if (!calib_done_q) begin
            if (calib_cnt == 32'(CALIB_CYCLES - 1)) begin
                calib_done_q <= 1'b1;
            end else begin
                calib_cnt <= calib_cnt + 32'd1;
            end
        end
    end

    assign port.calib_done = calib_done_q;

    // Only the word address is stored; byte-offset and high bits are dropped.
    emu_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH), .FWFT(1'b1)) u_cmd_fifo (
        .clk_50m (clk_50m),
        .sys_rst_i (sys_rst_i),
        .push    (port.cmd_en && calib_done_q),
        .din     ({port.cmd_instr, port.cmd_bl, port.cmd_byte_addr[ADDR_W+1:2]}),
        .pop     (cmd_pop),
        .dout    (cmd_head),
        .full    (cmd_full_raw),
        .empty   (cmd_empty_w),
        .count   ()
    );

    assign port.cmd_full  = cmd_full_raw || !calib_done_q;
    assign port.cmd_empty = cmd_empty_w;
    assign head_instr     = cmd_head[CMD_W-1 -: 3];
    assign head_bl        = cmd_head[ADDR_W +: 6];
    assign head_addr      = cmd_head[ADDR_W-1:0];

    emu_sync_fifo #(.WIDTH(36), .DEPTH(DATA_DEPTH), .FWFT(1'b1)) u_wr_fifo (
        .clk_50m (clk_50m),
        .sys_rst_i (sys_rst_i),
        .push    (port.wr_en),
        .din     ({port.wr_mask, port.wr_data}),
        .pop     (wr_pop),
        .dout    (wr_head),
        .full    (port.wr_full),
        .empty   (wr_empty_w),
        .count   (port.wr_count)
    );

    assign port.wr_empty = wr_empty_w;

    emu_sync_fifo #(.WIDTH(32), .DEPTH(DATA_DEPTH), .FWFT(1'b1)) u_rd_fifo (
        .clk_50m (clk_50m),
        .sys_rst_i (sys_rst_i),
        .push    (ret_valid),
        .din     (ret_data),
        .pop     (port.rd_en),
        .dout    (port.rd_data),
        .full    (port.rd_full),
        .empty   (port.rd_empty),
        .count   (rd_count_w)
    );

    assign port.rd_count = rd_count_w;

    // Words still in the RAM/return pipeline reserve read-FIFO space so the
    // FIFO can never be pushed while full.
    assign rd_pending = 8'(rd_count_w) + 8'(ram_q_valid) + 8'(ret_valid);
    assign rd_room    = rd_pending < 8'(DATA_DEPTH);

    assign port.wr_underrun = (state_q == ST_WRITE) && wr_empty_w;
    assign port.rd_overflow = (state_q == ST_READ) && !rd_room;

    always_ff @(posedge clk_50m or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            addr_q      <= '0;
`ifdef MCB_EMU_LATENCY_EN
            gap_q       <= '0;
            op_rd_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
`ifdef MCB_EMU_LATENCY_EN
            gap_q       <= gap_d;
            op_rd_q     <= op_rd_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        cmd_pop     = 1'b0;
        wr_pop      = 1'b0;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
`ifdef MCB_EMU_LATENCY_EN
        gap_d       = gap_q;
        op_rd_d     = op_rd_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Refresh and undefined codes are popped and dropped.
                if (!cmd_empty_w) begin
                    cmd_pop     = 1'b1;
                    addr_d      = head_addr;
                    remaining_d = {1'b0, head_bl} + 7'd1;
`ifdef MCB_EMU_LATENCY_EN
                    if (is_wr_instr(head_instr) || is_rd_instr(head_instr)) begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                        op_rd_d = is_rd_instr(head_instr);
                    end
`else
                    if (is_wr_instr(head_instr)) begin
                        state_d = ST_WRITE;
                    end else if (is_rd_instr(head_instr)) begin
                        state_d = ST_READ;
                    end
`endif
                end
            end
`ifdef MCB_EMU_LATENCY_EN
            ST_GAP: begin
                if (gap_q == 16'(CMD_GAP - 1)) begin
                    state_d = op_rd_q ? ST_READ : ST_WRITE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
`endif
            ST_WRITE: begin
                if (!wr_empty_w) begin
                    wr_pop      = 1'b1;
                    ram_we      = 1'b1;
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - 7'd1;
                    if (remaining_q == 7'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_READ: begin
                if (rd_room) begin
                    ram_re      = 1'b1;
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - 7'd1;
                    if (remaining_q == 7'd1) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Backing RAM: no reset so contents survive sys_rst_i.
    always_ff @(posedge clk_50m) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (!wr_head[32 + b]) begin
                    mem[addr_q][8*b +: 8] <= wr_head[8*b +: 8];
                end
            end
        end
        if (ram_re) begin
            ram_q <= mem[addr_q];
        end
    end

    // RAM output is re-registered before entering the read FIFO.
    always_ff @(posedge clk_50m or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            ram_q_valid <= 1'b0;
            ret_valid   <= 1'b0;
            ret_data    <= '0;
        end else begin
            ram_q_valid <= ram_re;
            ret_valid   <= ram_q_valid;
            ret_data    <= ram_q;
        end
    end

endmodule

// File: tb/tb_mcb_port_emu.sv
// tb_mcb_port_emu -- directed self-checking bench for mcb_port_emu
// (default build, MCB_EMU_LATENCY_EN undefined).
module tb_mcb_port_emu;
    import mcb_emu_pkg::*;

    localparam int CALIB     = 40;
    localparam int ADDR_W    = 12;
    localparam logic [29:0] WRAP_BYTE = 30'(((1 << ADDR_W) - 8) * 4);

    logic clk_50m = 1'b0;
    logic sys_rst_i = 1'b0;
    int   tests = 0;
    int   failed = 0;
    int   underrun_cycles = 0;

    always #10 clk_50m = ~clk_50m;

    mcb_port_emu_if bus ();

    mcb_port_emu #(.ADDR_W(ADDR_W), .CALIB_CYCLES(CALIB), .CMD_GAP(8)) dut (
        .clk_50m   (clk_50m),
        .sys_rst_i (sys_rst_i),
        .port      (bus)
    );

    // Counts cycles in which the engine reports a write-FIFO stall.
    always @(negedge clk_50m) begin
        if (bus.wr_underrun === 1'b1) underrun_cycles++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    // Pushes one command; called and returns at a negedge.
    task automatic applyStimulus(input logic [2:0] instr, input logic [5:0] bl,
                                 input logic [29:0] addr);
        bus.cmd_en        = 1'b1;
        bus.cmd_instr     = instr;
        bus.cmd_bl        = bl;
        bus.cmd_byte_addr = addr;
        @(negedge clk_50m);
        bus.cmd_en        = 1'b0;
    endtask

    task automatic pushWord(input logic [31:0] d, input logic [3:0] m);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        bus.wr_mask = m;
        @(negedge clk_50m);
        bus.wr_en   = 1'b0;
    endtask

    // Waits (bounded) for a read word, checks the head, then pops it.
    task automatic checkRead(input string tag, input logic [31:0] expected);
        int waited = 0;
        while (bus.rd_empty !== 1'b0 && waited < 300) begin
            @(negedge clk_50m);
            waited++;
        end
        if (bus.rd_empty !== 1'b0) begin
            checkOutput({tag, "_timeout"}, 32'(bus.rd_empty), 32'd0);
        end else begin
            checkOutput(tag, bus.rd_data, expected);
            bus.rd_en = 1'b1;
            @(negedge clk_50m);
            bus.rd_en = 1'b0;
        end
    endtask

    initial begin
        int waited;
        bus.cmd_en = 1'b0; bus.cmd_instr = INSTR_REFRESH; bus.cmd_bl = '0;
        bus.cmd_byte_addr = '0; bus.wr_en = 1'b0; bus.wr_mask = '0;
        bus.wr_data = '0; bus.rd_en = 1'b0;

        // Reset values
        tick(3);
        checkOutput("rst_calib_done", 32'(bus.calib_done), 32'd0);
        checkOutput("rst_cmd_full",   32'(bus.cmd_full),   32'd1);
        checkOutput("rst_cmd_empty",  32'(bus.cmd_empty),  32'd1);
        checkOutput("rst_wr_empty",   32'(bus.wr_empty),   32'd1);
        checkOutput("rst_rd_empty",   32'(bus.rd_empty),   32'd1);
        checkOutput("rst_wr_full",    32'(bus.wr_full),    32'd0);
        checkOutput("rst_rd_full",    32'(bus.rd_full),    32'd0);
        checkOutput("rst_wr_count",   32'(bus.wr_count),   32'd0);
        checkOutput("rst_rd_count",   32'(bus.rd_count),   32'd0);
        checkOutput("rst_rd_data",    bus.rd_data,         32'd0);
        checkOutput("rst_underrun",   32'(bus.wr_underrun), 32'd0);
        checkOutput("rst_overflow",   32'(bus.rd_overflow), 32'd0);

        // Calibration gating with cmd_en held high
        bus.cmd_en = 1'b1;
        sys_rst_i  = 1'b1;
        tick(CALIB - 1);
        checkOutput("calib_before",     32'(bus.calib_done), 32'd0);
        checkOutput("calib_cmd_full",   32'(bus.cmd_full),   32'd1);
        checkOutput("calib_cmd_empty",  32'(bus.cmd_empty),  32'd1);
        tick(1);
        checkOutput("calib_at",         32'(bus.calib_done), 32'd1);
        checkOutput("calib_cmd_full_0", 32'(bus.cmd_full),   32'd0);
        checkOutput("calib_no_accept",  32'(bus.cmd_empty),  32'd1);
        bus.cmd_en = 1'b0;
        tick(2);

        // 4-word write burst then read back, with edge-accurate timing
        for (int i = 0; i < 4; i++) pushWord(32'h11111111 * (i + 1), 4'b0000);
        checkOutput("wr_count_4", 32'(bus.wr_count), 32'd4);
        applyStimulus(INSTR_WR, 6'd3, 30'h100);
        tick(1);
        checkOutput("wr_n1_count", 32'(bus.wr_count), 32'd4);
        tick(1);
        checkOutput("wr_n2_count", 32'(bus.wr_count), 32'd3);
        tick(3);
        checkOutput("wr_done_empty", 32'(bus.wr_empty), 32'd1);
        applyStimulus(INSTR_RD_AP, 6'd3, 30'h100);
        tick(3);
        checkOutput("rd_n3_empty", 32'(bus.rd_empty), 32'd1);
        tick(1);
        checkOutput("rd_n4_empty", 32'(bus.rd_empty), 32'd0);
        for (int i = 0; i < 4; i++) checkRead("burst4", 32'h11111111 * (i + 1));
        checkOutput("burst4_no_underrun", 32'(underrun_cycles), 32'd0);

        // Byte mask: only byte 0 replaced
        pushWord(32'hAABBCCDD, 4'b0000);
        pushWord(32'h00000011, 4'b1110);
        applyStimulus(INSTR_WR, 6'd0, 30'h0);
        applyStimulus(INSTR_WR_AP, 6'd0, 30'h0);
        applyStimulus(INSTR_RD, 6'd0, 30'h0);
        checkRead("mask", 32'hAABBCC11);

        // Full write FIFO, wrapping 64-word write and read
        for (int i = 0; i < 64; i++) pushWord(32'hC0DE0000 + i, 4'b0000);
        checkOutput("wr_count_64", 32'(bus.wr_count), 32'd64);
        checkOutput("wr_full",     32'(bus.wr_full),  32'd1);
        pushWord(32'hDEADBEEF, 4'b0000);
        checkOutput("wr_push_when_full", 32'(bus.wr_count), 32'd64);
        applyStimulus(INSTR_WR, 6'd63, WRAP_BYTE);
        tick(70);
        checkOutput("wrap_wr_empty", 32'(bus.wr_empty), 32'd1);
        applyStimulus(INSTR_RD, 6'd63, WRAP_BYTE);
        waited = 0;
        while (bus.rd_count !== 7'd64 && waited < 300) begin tick(1); waited++; end
        tick(5);
        checkOutput("wrap_rd_count_64", 32'(bus.rd_count), 32'd64);
        checkOutput("wrap_rd_full",     32'(bus.rd_full),  32'd1);
        for (int i = 0; i < 64; i++) checkRead("wrap", 32'hC0DE0000 + i);
        applyStimulus(INSTR_RD, 6'd0, 30'h0);
        checkRead("wrap_addr0", 32'hC0DE0008);

        // Two queued 64-word reads with rd_en low -> overflow stall
        applyStimulus(INSTR_RD, 6'd63, WRAP_BYTE);
        applyStimulus(INSTR_RD, 6'd63, WRAP_BYTE);
        waited = 0;
        while (bus.rd_overflow !== 1'b1 && waited < 400) begin tick(1); waited++; end
        checkOutput("ovf_flag",  32'(bus.rd_overflow), 32'd1);
        checkOutput("ovf_count", 32'(bus.rd_count),    32'd64);
        for (int i = 0; i < 128; i++) checkRead("ovf", 32'hC0DE0000 + (i % 64));
        tick(5);
        checkOutput("ovf_cleared",  32'(bus.rd_overflow), 32'd0);
        checkOutput("ovf_rd_empty", 32'(bus.rd_empty),    32'd1);

        // Write burst started with only 3 of 8 words queued
        underrun_cycles = 0;
        for (int i = 0; i < 3; i++) pushWord(32'h5A000000 + i, 4'b0000);
        applyStimulus(INSTR_WR, 6'd7, 30'h200);
        tick(8);
        checkOutput("underrun_flag",  32'(bus.wr_underrun), 32'd1);
        checkOutput("underrun_count", 32'(bus.wr_count),    32'd0);
        for (int i = 3; i < 8; i++) pushWord(32'h5A000000 + i, 4'b0000);
        tick(4);
        checkOutput("underrun_clear", 32'(bus.wr_underrun), 32'd0);
        checkOutput("underrun_seen",  32'(underrun_cycles > 0), 32'd1);
        applyStimulus(INSTR_RD, 6'd7, 30'h200);
        for (int i = 0; i < 8; i++) checkRead("underrun_rb", 32'h5A000000 + i);

        // Reset mid-burst clears FIFOs/FSM, RAM keeps its data
        applyStimulus(INSTR_RD, 6'd63, WRAP_BYTE);
        tick(10);
        sys_rst_i = 1'b0;
        #2;
        checkOutput("midrst_rd_empty",  32'(bus.rd_empty),   32'd1);
        checkOutput("midrst_rd_count",  32'(bus.rd_count),   32'd0);
        checkOutput("midrst_rd_data",   bus.rd_data,         32'd0);
        checkOutput("midrst_calib",     32'(bus.calib_done), 32'd0);
        checkOutput("midrst_cmd_full",  32'(bus.cmd_full),   32'd1);
        tick(2);
        sys_rst_i = 1'b1;
        tick(CALIB + 1);
        checkOutput("midrst_recal", 32'(bus.calib_done), 32'd1);
        checkOutput("midrst_idle_rd_empty", 32'(bus.rd_empty), 32'd1);
        applyStimulus(INSTR_RD, 6'd0, 30'h200);
        checkRead("midrst_retain", 32'h5A000000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
